wbu: RTL and testbench
======================

# wbu

Writeback stage of the five-stage core: accepts completed instructions from the memory stage over a valid/ready handshake, holds them in one pipeline register, forms the final result (load extraction and sign/zero extension, PC+4 link, CSR read value), and drives the register file write port. It also owns the per-register pending-write scoreboard that decode queries to stall read-after-write hazards.

## Interface
- SB_CNTW, 2, width of each scoreboard counter; max outstanding writes per register = 2^SB_CNTW-1
- Widths `CPU_WIDTH` (64) and `REG_ADDRW` (5) come from config.sv.
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_pre_valid  in  1  memory stage has an instruction
- o_pre_ready  out  1  wbu accepts
- i_pre_pc  in  64  instruction PC
- i_pre_rdwen  in  1  instruction writes rd
- i_pre_rdaddr  in  5  rd
- i_pre_src  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 CSR
- i_pre_exres  in  64  ALU/CSR result
- i_pre_lddata  in  64  aligned doubleword read from memory
- i_pre_ldop  in  3  load funct3
- i_pre_addrlo  in  3  load address bits [2:0]
- o_rf_wen / o_rf_waddr / o_rf_wdata  out  1/5/64  register file write port
- i_iss_valid  in  1  decode issues an instruction this cycle
- i_iss_rdwen  in  1  issued instruction writes rd
- i_iss_rd  in  5  issued rd
- o_iss_stall  out  1  counter of i_iss_rd saturated; decode must not issue
- i_qry_raddr1, i_qry_raddr2  in  5  decode source registers
- o_qry_busy1, o_qry_busy2  out  1  source has a pending write
- o_cmt_valid  out  1  instruction retires this cycle
- o_cmt_pc  out  64  retiring PC
- o_byp_valid / o_byp_addr / o_byp_data  out  1/5/64  bypass (only with WBU_BYPASS_EN)

## Operation
- o_pre_ready = ~i_rst; wbu never back-pressures. Fire = i_pre_valid & o_pre_ready loads the stage register; no fire clears its valid bit.
- From the stage register (combinational): o_cmt_valid = valid; o_rf_wen = valid & rdwen & (rdaddr != 0); o_rf_waddr = rdaddr.
- Result: src 00/11 → exres; 10 → pc+4 (64-bit wrap); 01 → load.
- Load: shifted = lddata >> (addrlo*8); ldop 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 110 LWU sign/zero-extend bits [7:0]/[15:0]/[31:0]; 011 and reserved 111 → full 64 bits unshifted. No alignment check; bits shifted out are lost.
- Scoreboard: 32 counters of SB_CNTW bits. Increment on i_iss_valid & i_iss_rdwen & i_iss_rd != 0 & ~o_iss_stall. Decrement on o_rf_wen for o_rf_waddr. Increment and decrement on the same register in the same cycle → unchanged. Counter 0 never changes; decrement at 0 holds 0.
- o_iss_stall = (count[i_iss_rd] == max) & (i_iss_rd != 0); a stalled issue is ignored.
- o_qry_busyN = (count[raddrN] != 0); x0 is never busy.

## Timing
- Reset: stage valid 0, all counters 0; o_rf_wen, o_cmt_valid, o_byp_valid, o_qry_busy*, o_iss_stall are 0; o_pre_ready is 0 while i_rst is high.
- Fire at edge E → o_rf_wen/o_cmt_valid high during cycle after E → regfile updated and counter decremented at edge E+1.
- Busy is still 1 in the cycle the write is presented; it drops in the following cycle.
- Reset mid-operation drops the in-flight write; the regfile is not written.
- Back-to-back fires retire one instruction per cycle.

## Configuration
- WBU_BYPASS_EN defined: o_byp_valid = o_rf_wen, o_byp_addr = o_rf_waddr, o_byp_data = o_rf_wdata. Decode may take these in place of a busy source when busy count == 1.
- Undefined: bypass ports are tied to 0; decode waits one more cycle.

## Structure
- Shared package: result-source enum (ALU, LOAD, PC4, CSR), load funct3 constants, and SB_CNTW default.
- One sub-module: wbu_scoreboard (counters, stall, queries); load extension stays inline.

## Test plan
- ALU result: fire rd=5, src 00, exres 0x1234 → next cycle o_rf_wen=1, waddr 5, wdata 0x1234, o_cmt_pc = given PC.
- LB at addrlo=3, lddata 0x0000_0000_80FF_0000 with byte 3 = 0x80 → wdata 0xFFFF_FFFF_FFFF_FF80; LBU → 0x80; LWU at addrlo=4 of 0xDEADBEEF_00000000 → 0xDEADBEEF.
- rd=0 with rdwen=1 → o_rf_wen=0, o_cmt_valid=1; x0 never busy.
- Issue rd=7 three times (SB_CNTW=2) → busy, fourth issue sees o_iss_stall=1 and is ignored; three writebacks → busy clears the cycle after the third.
- Issue and writeback of rd=9 in the same cycle with count 1 → count stays 1.
- Assert i_rst while stage valid with rd=3 → no write, all counters 0, o_pre_ready=0 until reset releases.

Source files
------------

// File: rtl/wbu_pkg.sv
// ============================================================================
// Module  : wbu_pkg
// Purpose : Shared types and constants for the writeback stage: datapath
//           widths, result-source encoding, load funct3 codes, the stage
//           register layout and the default scoreboard counter width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wbu_pkg;

  localparam int CPU_WIDTH   = 64;
  localparam int REG_ADDRW   = 5;
  localparam int NUM_REGS    = 32;
  localparam int SB_CNTW_DEF = 2;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_CSR  = 2'b11
  } wb_src_e;

  localparam logic [2:0] LDOP_LB  = 3'b000;
  localparam logic [2:0] LDOP_LH  = 3'b001;
  localparam logic [2:0] LDOP_LW  = 3'b010;
  localparam logic [2:0] LDOP_LD  = 3'b011;
  localparam logic [2:0] LDOP_LBU = 3'b100;
  localparam logic [2:0] LDOP_LHU = 3'b101;
  localparam logic [2:0] LDOP_LWU = 3'b110;

  // Payload captured from the memory stage on a fire
  typedef struct packed {
    logic [CPU_WIDTH-1:0] pc;
    logic                 rdwen;
    logic [REG_ADDRW-1:0] rdaddr;
    wb_src_e              src;
    logic [CPU_WIDTH-1:0] exres;
    logic [CPU_WIDTH-1:0] lddata;
    logic [2:0]           ldop;
    logic [2:0]           addrlo;
  } stage_t;

endpackage

`default_nettype wire

// File: rtl/wbu_scoreboard.sv
// ============================================================================
// Module  : wbu_scoreboard
// Purpose : Per-register pending-write counters. Decode increments on issue,
//           writeback decrements on regfile write. Reports issue stall when
//           the target counter is saturated and busy status for two sources.
// Ports   : clk_i, rst_i           clock, synchronous active-high reset
//           iss_valid_i/rdwen_i/rd_i  issue request from decode
//           iss_stall_o            target counter saturated
//           wb_wen_i, wb_waddr_i   regfile write (decrement)
//           qry_raddr{1,2}_i       source queries
//           qry_busy{1,2}_o        source has pending write(s)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wbu_scoreboard
  import wbu_pkg::*;
#(
  parameter int SB_CNTW = SB_CNTW_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 iss_valid_i,
  input  logic                 iss_rdwen_i,
  input  logic [REG_ADDRW-1:0] iss_rd_i,
  output logic                 iss_stall_o,
  input  logic                 wb_wen_i,
  input  logic [REG_ADDRW-1:0] wb_waddr_i,
  input  logic [REG_ADDRW-1:0] qry_raddr1_i,
  input  logic [REG_ADDRW-1:0] qry_raddr2_i,
  output logic                 qry_busy1_o,
  output logic                 qry_busy2_o
);

  localparam logic [SB_CNTW-1:0] CNT_MAX = '1;

  logic [SB_CNTW-1:0] cnt_q [NUM_REGS];
  logic [SB_CNTW-1:0] cnt_d [NUM_REGS];
  logic               inc_en;

  assign iss_stall_o = (cnt_q[iss_rd_i] == CNT_MAX) && (iss_rd_i != '0);
  assign inc_en      = iss_valid_i & iss_rdwen_i & (iss_rd_i != '0) & ~iss_stall_o;

  // Counter 0 is pinned to zero, so x0 never reads as busy
  assign qry_busy1_o = (cnt_q[qry_raddr1_i] != '0);
  assign qry_busy2_o = (cnt_q[qry_raddr2_i] != '0);

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (inc_en && (iss_rd_i == REG_ADDRW'(r)) &&
                   !(wb_wen_i && (wb_waddr_i == REG_ADDRW'(r)))) begin
        cnt_d[r] = cnt_q[r] + SB_CNTW'(1);
      end else if (wb_wen_i && (wb_waddr_i == REG_ADDRW'(r)) &&
                   !(inc_en && (iss_rd_i == REG_ADDRW'(r))) &&
                   (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - SB_CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wbu.sv
// ============================================================================
// Module  : wbu
// Purpose : Writeback stage. Single pipeline register fed by a never-stalling
//           valid/ready handshake; forms the final result (ALU, load with
//           extension, PC+4, CSR) and drives the regfile write port and the
//           commit interface. Hosts the pending-write scoreboard.
// Ports   : i_clk, i_rst                  clock, synchronous active-high reset
//           i_pre_* / o_pre_ready         memory-stage handshake and payload
//           o_rf_wen/waddr/wdata          regfile write port
//           i_iss_* / o_iss_stall         decode issue into the scoreboard
//           i_qry_raddr* / o_qry_busy*    decode source-busy queries
//           o_cmt_valid, o_cmt_pc         retirement
//           o_byp_valid/addr/data         bypass of the write port
// Config  : WBU_BYPASS_EN - when defined, bypass outputs mirror the write
//           port; otherwise they are tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wbu
  import wbu_pkg::*;
#(
  parameter int SB_CNTW = SB_CNTW_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic [CPU_WIDTH-1:0] i_pre_pc,
  input  logic                 i_pre_rdwen,
  input  logic [REG_ADDRW-1:0] i_pre_rdaddr,
  input  logic [1:0]           i_pre_src,
  input  logic [CPU_WIDTH-1:0] i_pre_exres,
  input  logic [CPU_WIDTH-1:0] i_pre_lddata,
  input  logic [2:0]           i_pre_ldop,
  input  logic [2:0]           i_pre_addrlo,
  output logic                 o_rf_wen,
  output logic [REG_ADDRW-1:0] o_rf_waddr,
  output logic [CPU_WIDTH-1:0] o_rf_wdata,
  input  logic                 i_iss_valid,
  input  logic                 i_iss_rdwen,
  input  logic [REG_ADDRW-1:0] i_iss_rd,
  output logic                 o_iss_stall,
  input  logic [REG_ADDRW-1:0] i_qry_raddr1,
  input  logic [REG_ADDRW-1:0] i_qry_raddr2,
  output logic                 o_qry_busy1,
  output logic                 o_qry_busy2,
  output logic                 o_cmt_valid,
  output logic [CPU_WIDTH-1:0] o_cmt_pc,
  output logic                 o_byp_valid,
  output logic [REG_ADDRW-1:0] o_byp_addr,
  output logic [CPU_WIDTH-1:0] o_byp_data
);

  logic                 fire;
  logic                 valid_q, valid_d;
  stage_t               stage_q, stage_d;
  logic [CPU_WIDTH-1:0] ld_shift;
  logic [CPU_WIDTH-1:0] ld_res;
  logic [CPU_WIDTH-1:0] wb_res;

  assign o_pre_ready = ~i_rst;
  assign fire        = i_pre_valid & o_pre_ready;

  always_comb begin
    valid_d = fire;
    stage_d = stage_q;
    if (fire) begin
      stage_d.pc     = i_pre_pc;
      stage_d.rdwen  = i_pre_rdwen;
      stage_d.rdaddr = i_pre_rdaddr;
      stage_d.src    = wb_src_e'(i_pre_src);
      stage_d.exres  = i_pre_exres;
      stage_d.lddata = i_pre_lddata;
      stage_d.ldop   = i_pre_ldop;
      stage_d.addrlo = i_pre_addrlo;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
    end
  end

  // Byte-lane select; high bytes shifted past bit 63 are simply lost
  assign ld_shift = stage_q.lddata >> {stage_q.addrlo, 3'b000};

  always_comb begin
    ld_res = stage_q.lddata;
    case (stage_q.ldop)
      LDOP_LB:  ld_res = {{56{ld_shift[7]}},  ld_shift[7:0]};
      LDOP_LH:  ld_res = {{48{ld_shift[15]}}, ld_shift[15:0]};
      LDOP_LW:  ld_res = {{32{ld_shift[31]}}, ld_shift[31:0]};
      LDOP_LBU: ld_res = {56'd0, ld_shift[7:0]};
      LDOP_LHU: ld_res = {48'd0, ld_shift[15:0]};
      LDOP_LWU: ld_res = {32'd0, ld_shift[31:0]};
      default:  ld_res = stage_q.lddata;
    endcase
  end

  always_comb begin
    wb_res = stage_q.exres;
    case (stage_q.src)
      SRC_LOAD: wb_res = ld_res;
      SRC_PC4:  wb_res = stage_q.pc + 64'd4;
      default:  wb_res = stage_q.exres;
    endcase
  end

  // Gated by reset so an in-flight instruction is dropped rather than
  // written on the reset edge
  assign o_cmt_valid = valid_q & ~i_rst;
  assign o_cmt_pc    = stage_q.pc;
  assign o_rf_wen    = o_cmt_valid & stage_q.rdwen & (stage_q.rdaddr != '0);
  assign o_rf_waddr  = stage_q.rdaddr;
  assign o_rf_wdata  = wb_res;

`ifdef WBU_BYPASS_EN
  assign o_byp_valid = o_rf_wen;
  assign o_byp_addr  = o_rf_waddr;
  assign o_byp_data  = o_rf_wdata;
`else
  assign o_byp_valid = 1'b0;
  assign o_byp_addr  = '0;
  assign o_byp_data  = '0;
`endif

  wbu_scoreboard #(
    .SB_CNTW (SB_CNTW)
  ) u_sb (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .iss_valid_i  (i_iss_valid),
    .iss_rdwen_i  (i_iss_rdwen),
    .iss_rd_i     (i_iss_rd),
    .iss_stall_o  (o_iss_stall),
    .wb_wen_i     (o_rf_wen),
    .wb_waddr_i   (o_rf_waddr),
    .qry_raddr1_i (i_qry_raddr1),
    .qry_raddr2_i (i_qry_raddr2),
    .qry_busy1_o  (o_qry_busy1),
    .qry_busy2_o  (o_qry_busy2)
  );

endmodule

`default_nettype wire

// File: tb/tb_wbu.sv
// ============================================================================
// Module  : tb_wbu
// Purpose : Self-checking bench for wbu. Stimulus pushes expected commits into
//           a queue; a monitor pops and compares on every o_cmt_valid.
//           Scoreboard busy/stall behaviour is checked directly.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wbu;

  logic        i_clk;
  logic        i_rst;
  logic        i_pre_valid;
  logic        o_pre_ready;
  logic [63:0] i_pre_pc;
  logic        i_pre_rdwen;
  logic [4:0]  i_pre_rdaddr;
  logic [1:0]  i_pre_src;
  logic [63:0] i_pre_exres;
  logic [63:0] i_pre_lddata;
  logic [2:0]  i_pre_ldop;
  logic [2:0]  i_pre_addrlo;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [63:0] o_rf_wdata;
  logic        i_iss_valid;
  logic        i_iss_rdwen;
  logic [4:0]  i_iss_rd;
  logic        o_iss_stall;
  logic [4:0]  i_qry_raddr1;
  logic [4:0]  i_qry_raddr2;
  logic        o_qry_busy1;
  logic        o_qry_busy2;
  logic        o_cmt_valid;
  logic [63:0] o_cmt_pc;
  logic        o_byp_valid;
  logic [4:0]  o_byp_addr;
  logic [63:0] o_byp_data;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  wbu dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pre_valid  (i_pre_valid),
    .o_pre_ready  (o_pre_ready),
    .i_pre_pc     (i_pre_pc),
    .i_pre_rdwen  (i_pre_rdwen),
    .i_pre_rdaddr (i_pre_rdaddr),
    .i_pre_src    (i_pre_src),
    .i_pre_exres  (i_pre_exres),
    .i_pre_lddata (i_pre_lddata),
    .i_pre_ldop   (i_pre_ldop),
    .i_pre_addrlo (i_pre_addrlo),
    .o_rf_wen     (o_rf_wen),
    .o_rf_waddr   (o_rf_waddr),
    .o_rf_wdata   (o_rf_wdata),
    .i_iss_valid  (i_iss_valid),
    .i_iss_rdwen  (i_iss_rdwen),
    .i_iss_rd     (i_iss_rd),
    .o_iss_stall  (o_iss_stall),
    .i_qry_raddr1 (i_qry_raddr1),
    .i_qry_raddr2 (i_qry_raddr2),
    .o_qry_busy1  (o_qry_busy1),
    .o_qry_busy2  (o_qry_busy2),
    .o_cmt_valid  (o_cmt_valid),
    .o_cmt_pc     (o_cmt_pc),
    .o_byp_valid  (o_byp_valid),
    .o_byp_addr   (o_byp_addr),
    .o_byp_data   (o_byp_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present one instruction for exactly one cycle; optionally record the
  // commit it should produce
  task automatic fire(input logic [63:0] pc, input logic rdwen, input logic [4:0] rd,
                      input logic [1:0] src, input logic [63:0] exres,
                      input logic [63:0] lddata, input logic [2:0] ldop,
                      input logic [2:0] addrlo, input logic exp_wen,
                      input logic [63:0] exp_wdata);
    exp_t e;
    i_pre_valid  = 1'b1;
    i_pre_pc     = pc;
    i_pre_rdwen  = rdwen;
    i_pre_rdaddr = rd;
    i_pre_src    = src;
    i_pre_exres  = exres;
    i_pre_lddata = lddata;
    i_pre_ldop   = ldop;
    i_pre_addrlo = addrlo;
    e.pc    = pc;
    e.wen   = exp_wen;
    e.waddr = rd;
    e.wdata = exp_wdata;
    exp_q.push_back(e);
    step();
    i_pre_valid = 1'b0;
  endtask

  // Monitor: every retirement must match the oldest expected entry
  initial begin
    exp_t e;
    logic exp_bv;
    forever begin
      @(negedge i_clk);
      if (o_cmt_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL commit_unexpected: got pc=%h wen=%b waddr=%0d required no commit",
                   o_cmt_pc, o_rf_wen, o_rf_waddr);
        end else begin
          e = exp_q.pop_front();
`ifdef WBU_BYPASS_EN
          exp_bv = e.wen;
`else
          exp_bv = 1'b0;
`endif
          if (o_cmt_pc !== e.pc || o_rf_wen !== e.wen || o_rf_waddr !== e.waddr ||
              (e.wen && o_rf_wdata !== e.wdata) || o_byp_valid !== exp_bv) begin
            n_fail++;
            $display("FAIL commit pc=%h: got wen=%b waddr=%0d wdata=%h byp=%b required wen=%b waddr=%0d wdata=%h byp=%b (pc got %h)",
                     e.pc, o_rf_wen, o_rf_waddr, o_rf_wdata, o_byp_valid,
                     e.wen, e.waddr, e.wdata, exp_bv, o_cmt_pc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1;
    i_pre_valid = 0; i_pre_pc = 0; i_pre_rdwen = 0; i_pre_rdaddr = 0; i_pre_src = 0;
    i_pre_exres = 0; i_pre_lddata = 0; i_pre_ldop = 0; i_pre_addrlo = 0;
    i_iss_valid = 0; i_iss_rdwen = 0; i_iss_rd = 0;
    i_qry_raddr1 = 5'd5; i_qry_raddr2 = 5'd6;

    // Reset state
    step(); step();
    @(negedge i_clk);
    check("rst_pre_ready", 64'(o_pre_ready), 64'd0);
    check("rst_rf_wen",    64'(o_rf_wen),    64'd0);
    check("rst_cmt_valid", 64'(o_cmt_valid), 64'd0);
    check("rst_stall",     64'(o_iss_stall), 64'd0);
    check("rst_busy1",     64'(o_qry_busy1), 64'd0);
    check("rst_byp_valid", 64'(o_byp_valid), 64'd0);
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    check("pre_ready_out_of_rst", 64'(o_pre_ready), 64'd1);
    step();

    // Back-to-back result forms
    fire(64'h1000, 1, 5'd5, 2'b00, 64'h1234, 64'h0, 3'd0, 3'd0, 1, 64'h1234);
    fire(64'h1004, 1, 5'd6, 2'b01, 64'h0, 64'h0000_0000_80FF_0000, 3'b000, 3'd3, 1, 64'hFFFF_FFFF_FFFF_FF80);
    fire(64'h1008, 1, 5'd6, 2'b01, 64'h0, 64'h0000_0000_80FF_0000, 3'b100, 3'd3, 1, 64'h0000_0000_0000_0080);
    fire(64'h100C, 1, 5'd8, 2'b01, 64'h0, 64'hDEAD_BEEF_0000_0000, 3'b110, 3'd4, 1, 64'h0000_0000_DEAD_BEEF);
    fire(64'h1010, 1, 5'd8, 2'b01, 64'h0, 64'hDEAD_BEEF_0000_0000, 3'b010, 3'd4, 1, 64'hFFFF_FFFF_DEAD_BEEF);
    fire(64'h1014, 1, 5'd10, 2'b01, 64'h0, 64'h0000_0000_80FF_0000, 3'b001, 3'd2, 1, 64'hFFFF_FFFF_FFFF_80FF);
    fire(64'h1018, 1, 5'd10, 2'b01, 64'h0, 64'h0000_0000_80FF_0000, 3'b101, 3'd2, 1, 64'h0000_0000_0000_80FF);
    fire(64'h101C, 1, 5'd11, 2'b01, 64'h0, 64'h0000_0000_80FF_0000, 3'b011, 3'd3, 1, 64'h0000_0000_80FF_0000);
    fire(64'h1020, 1, 5'd11, 2'b01, 64'h0, 64'h0000_0000_80FF_0000, 3'b111, 3'd3, 1, 64'h0000_0000_80FF_0000);
    fire(64'hFFFF_FFFF_FFFF_FFFC, 1, 5'd1, 2'b10, 64'h5555, 64'h0, 3'd0, 3'd0, 1, 64'h0);
    fire(64'h2000, 1, 5'd1, 2'b10, 64'h5555, 64'h0, 3'd0, 3'd0, 1, 64'h2004);
    fire(64'h2004, 1, 5'd12, 2'b11, 64'hABCD, 64'h0, 3'd0, 3'd0, 1, 64'hABCD);
    fire(64'h2008, 1, 5'd0, 2'b00, 64'h7777, 64'h0, 3'd0, 3'd0, 0, 64'h0);
    fire(64'h200C, 0, 5'd4, 2'b00, 64'h8888, 64'h0, 3'd0, 3'd0, 0, 64'h0);
    step(); step();
    check("drain1_queue_empty", 64'(exp_q.size()), 64'd0);

    // x0 is never busy
    i_qry_raddr1 = 5'd0;
    @(negedge i_clk);
    check("x0_busy", 64'(o_qry_busy1), 64'd0);
    step();

    // Saturate rd=7 (max 3 outstanding)
    i_qry_raddr1 = 5'd7;
    i_iss_valid = 1'b1; i_iss_rdwen = 1'b1; i_iss_rd = 5'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("stall7_below_max", 64'(o_iss_stall), 64'd0);
      step();
    end
    @(negedge i_clk);
    check("stall7_at_max", 64'(o_iss_stall), 64'd1);
    check("busy7_at_max",  64'(o_qry_busy1), 64'd1);
    step();
    i_iss_valid = 1'b0;
    @(negedge i_clk);
    check("busy7_after_ignored_issue", 64'(o_qry_busy1), 64'd1);
    check("stall7_still_max", 64'(o_iss_stall), 64'd1);
    step();
    fire(64'h3000, 1, 5'd7, 2'b00, 64'h70, 64'h0, 3'd0, 3'd0, 1, 64'h70);
    fire(64'h3004, 1, 5'd7, 2'b00, 64'h71, 64'h0, 3'd0, 3'd0, 1, 64'h71);
    fire(64'h3008, 1, 5'd7, 2'b00, 64'h72, 64'h0, 3'd0, 3'd0, 1, 64'h72);
    @(negedge i_clk);
    check("busy7_during_last_wb", 64'(o_qry_busy1), 64'd1);
    step();
    @(negedge i_clk);
    check("busy7_cleared", 64'(o_qry_busy1), 64'd0);
    check("stall7_cleared", 64'(o_iss_stall), 64'd0);
    step();

    // Simultaneous issue and writeback of rd=9 at count 1
    i_qry_raddr2 = 5'd9;
    i_iss_valid = 1'b1; i_iss_rd = 5'd9;
    step();
    i_iss_valid = 1'b0;
    fire(64'h4000, 1, 5'd9, 2'b00, 64'h99, 64'h0, 3'd0, 3'd0, 1, 64'h99);
    i_iss_valid = 1'b1;
    @(negedge i_clk);
    check("busy9_same_cycle", 64'(o_qry_busy2), 64'd1);
    step();
    i_iss_valid = 1'b0;
    @(negedge i_clk);
    check("busy9_count_unchanged", 64'(o_qry_busy2), 64'd1);
    step();
    fire(64'h4004, 1, 5'd9, 2'b00, 64'h9A, 64'h0, 3'd0, 3'd0, 1, 64'h9A);
    @(negedge i_clk);
    check("busy9_last_wb", 64'(o_qry_busy2), 64'd1);
    step();
    @(negedge i_clk);
    check("busy9_cleared", 64'(o_qry_busy2), 64'd0);
    step();

    // Reset while rd=3 is in the stage register
    i_qry_raddr1 = 5'd3;
    i_iss_valid = 1'b1; i_iss_rd = 5'd3;
    step();
    i_iss_valid = 1'b0;
    @(negedge i_clk);
    check("busy3_before_rst", 64'(o_qry_busy1), 64'd1);
    i_pre_valid = 1'b1; i_pre_pc = 64'h5000; i_pre_rdwen = 1'b1; i_pre_rdaddr = 5'd3;
    i_pre_src = 2'b00; i_pre_exres = 64'h33;
    step();
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rst_inflight_rf_wen", 64'(o_rf_wen),    64'd0);
    check("rst_inflight_cmt",    64'(o_cmt_valid), 64'd0);
    check("rst_inflight_ready",  64'(o_pre_ready), 64'd0);
    step();
    @(negedge i_clk);
    check("rst_busy3_cleared", 64'(o_qry_busy1), 64'd0);
    check("rst_ready_held",    64'(o_pre_ready), 64'd0);
    step();
    i_rst = 1'b0;
    i_pre_valid = 1'b0;
    @(negedge i_clk);
    check("post_rst_cmt",   64'(o_cmt_valid), 64'd0);
    check("post_rst_ready", 64'(o_pre_ready), 64'd1);
    step(); step();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
